// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: ALU op encodings plus the multiply/divide unit's
// op encodings, FSM states and iteration count.
package rv32_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  localparam int MULDIV_ITERS = 32;

endpackage

// File: rtl/rv32m_muldiv_if.sv
// Request/response channels between the datapath (master) and the
// multiply/divide unit (slave), plus busy and FSM state for observation.
interface rv32m_muldiv_if;
  import rv32_pkg::*;

  // A transfer happens on a rising edge where valid && ready; the sender keeps
  // its payload stable while valid is high and ready is low.
  logic          req_valid;
  logic          req_ready;
  muldiv_op_t    req_op;
  logic [31:0]   req_a;
  logic [31:0]   req_b;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_y;
  logic          busy;
  muldiv_state_t dbg_state;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_y, busy, dbg_state
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_y, busy, dbg_state
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: LSB-first shift-add for multiply, MSB-first
// restoring subtract for divide, on unsigned magnitudes.
module muldiv_step (
  input  logic        is_div,
  input  logic [31:0] acc_hi,
  input  logic [31:0] acc_lo,
  input  logic [31:0] operand,
  output logic [31:0] nxt_hi,
  output logic [31:0] nxt_lo
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic [31:0] diff;
  logic        ge;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : 33'd0);
    // 33-bit partial remainder; when it fits the divisor the result is < 2^32
    shifted = {acc_hi, acc_lo[31]};
    ge      = shifted[32] | (shifted[31:0] >= operand);
    diff    = shifted[31:0] - operand;
    nxt_hi  = sum[32:1];
    nxt_lo  = {sum[0], acc_lo[31:1]};
    if (is_div) begin
      nxt_hi = ge ? diff : shifted[31:0];
      nxt_lo = {acc_lo[30:0], ge};
    end
  end

endmodule

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide unit: operands become magnitudes at
// acceptance, 32 radix-2 steps run in CALC, sign is restored on completion.
module rv32m_muldiv
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic            clk,
  input logic            rst_n,
  rv32m_muldiv_if.slave  bus
);

  muldiv_state_t   state;
  logic [4:0]      cnt;
  muldiv_op_t      op;
  logic            neg_res;
  logic [XLEN-1:0] acc_hi, acc_lo, operand, y_q;

  logic            a_sgn, b_sgn, neg_a, neg_b, neg_in, fast;
  logic [XLEN-1:0] mag_a, mag_b, fast_y, step_hi, step_lo, q_s, r_s, done_y;
  logic [63:0]     prod, prod_s;

  always_comb begin
    a_sgn  = bus.req_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_sgn  = bus.req_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    neg_a  = a_sgn & bus.req_a[31];
    neg_b  = b_sgn & bus.req_b[31];
    mag_a  = neg_a ? (~bus.req_a + 32'd1) : bus.req_a;
    mag_b  = neg_b ? (~bus.req_b + 32'd1) : bus.req_b;
    // Remainder takes the dividend's sign; product and quotient the xor
    neg_in = (bus.req_op inside {OP_REM, OP_REMU}) ? neg_a : (neg_a ^ neg_b);
    fast   = 1'b0;
    fast_y = '0;
    if (bus.req_op[2] && bus.req_b == 32'd0) begin
      fast   = 1'b1;
      fast_y = bus.req_op[1] ? bus.req_a : 32'hFFFF_FFFF;
    end else if ((bus.req_op == OP_DIV || bus.req_op == OP_REM) &&
                 bus.req_a == 32'h8000_0000 && bus.req_b == 32'hFFFF_FFFF) begin
      fast   = 1'b1;
      fast_y = bus.req_op[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  muldiv_step u_step (
    .is_div  (op[2]),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .operand (operand),
    .nxt_hi  (step_hi),
    .nxt_lo  (step_lo)
  );

  always_comb begin
    prod   = {step_hi, step_lo};
    prod_s = neg_res ? (~prod + 64'd1) : prod;
    q_s    = neg_res ? (~step_lo + 32'd1) : step_lo;
    r_s    = neg_res ? (~step_hi + 32'd1) : step_hi;
    unique case (op)
      OP_MUL:                       done_y = prod_s[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: done_y = prod_s[63:32];
      OP_DIV, OP_DIVU:              done_y = q_s;
      default:                      done_y = r_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= OP_MUL;
      neg_res <= 1'b0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      operand <= '0;
      y_q     <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.req_valid) begin
          op      <= bus.req_op;
          neg_res <= neg_in;
          cnt     <= '0;
          if (fast) begin
            y_q   <= fast_y;
            state <= DONE;
          end else begin
            // Multiplier and dividend both start in the low accumulator
            acc_hi  <= '0;
            acc_lo  <= mag_a;
            operand <= mag_b;
            state   <= CALC;
          end
        end
        CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'(MULDIV_ITERS - 1)) begin
            y_q   <= done_y;
            state <= DONE;
          end
        end
        DONE: if (bus.resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.resp_y     = y_q;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_rv32m_muldiv.sv
// Directed-vector bench for rv32m_muldiv: results, latency, handshake,
// backpressure and asynchronous reset.
module tb_rv32m_muldiv;
  import rv32_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rv32m_muldiv_if bus ();

  rv32m_muldiv #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    int w;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    w = 0;
    while (!bus.req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready: req_ready=%b required 1", bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = muldiv_op_t'(3'($urandom_range(0, 7)));
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
  endtask

  task automatic run_op(input string name, input muldiv_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit fast);
    int cyc;
    bit saw_rdy;
    bus.resp_ready = 1'b0;
    issue(op, a, b);
    cyc = 0;
    saw_rdy = 1'b0;
    while (!bus.resp_valid && cyc < 64) begin
      if (bus.req_ready) saw_rdy = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    n_cmp++;
    if (fast ? (cyc > 1) : (cyc != 32)) begin
      n_fail++;
      $display("FAIL %s_latency: resp_valid after %0d edges, required %s", name, cyc,
               fast ? "<=1" : "32");
    end
    n_cmp++;
    if (bus.resp_y !== exp) begin
      n_fail++;
      $display("FAIL %s_result: resp_y=%h required %h", name, bus.resp_y, exp);
    end
    n_cmp++;
    if (saw_rdy || bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_busy: req_ready_seen=%b req_ready=%b busy=%b required 0/0/1", name,
               saw_rdy, bus.req_ready, bus.busy);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    n_cmp++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_release: resp_valid=%b req_ready=%b required 0/1", name,
               bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = OP_MUL;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    #22;
    n_cmp++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: req_ready=%b resp_valid=%b busy=%b required 1/0/0",
               bus.req_ready, bus.resp_valid, bus.busy);
    end
    n_cmp++;
    if (bus.resp_y !== 32'd0 || bus.dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: resp_y=%h state=%0d required 0/IDLE", bus.resp_y,
               bus.dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul;
    run_op("mul_7xm3",  OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_op("mulh_min",  OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run_op("mulhu_max", OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op("mulhsu_m1", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mul_zero",  OP_MUL,    32'd0,         32'h1234_5678, 32'd0,         1'b0);
  endtask

  task automatic test_div;
    run_op("div_m7_2", OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_op("rem_m7_2", OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_100", OP_DIVU, 32'd100,       32'd7, 32'h0000_000E, 1'b0);
    run_op("remu_100", OP_REMU, 32'd100,       32'd7, 32'd2,         1'b0);
  endtask

  task automatic test_fast_path;
    run_op("div_by0",  OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1);
    run_op("remu_by0", OP_REMU, 32'd5,         32'd0,         32'd5,         1'b1);
    run_op("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1);
  endtask

  task automatic test_backpressure;
    int w;
    bus.resp_ready = 1'b0;
    issue(OP_DIVU, 32'h1234_5678, 32'h0000_0010);
    w = 0;
    while (!bus.resp_valid && w < 64) begin
      @(posedge clk);
      #1;
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.req_a = 32'hDEAD_BEEF;
        bus.req_b = 32'd1;
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.resp_y !== 32'h0123_4567 || bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: resp_y=%h resp_valid=%b req_ready=%b required 01234567/1/0",
                 i, bus.resp_y, bus.resp_valid, bus.req_ready);
      end
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    n_cmp++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_y !== 32'h0123_4567) begin
      n_fail++;
      $display("FAIL bp_release: req_ready=%b resp_valid=%b resp_y=%h required 1/0/01234567",
               bus.req_ready, bus.resp_valid, bus.resp_y);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, n_acc, acc0, acc1, w;
    logic [31:0] first_y;
    bit got_first;
    logic rr;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_MULHU;
    bus.req_a     = 32'hFFFF_FFFF;
    bus.req_b     = 32'hFFFF_FFFF;
    n_acc = 0; cyc = 0; acc0 = 0; acc1 = 0; got_first = 1'b0; first_y = '0;
    while (n_acc < 2 && cyc < 100) begin
      rr = bus.req_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (rr) begin
        n_acc++;
        if (n_acc == 1) begin
          acc0 = cyc;
          bus.req_op = OP_DIVU;
          bus.req_a  = 32'd100;
          bus.req_b  = 32'd7;
        end else begin
          acc1 = cyc;
          bus.req_valid = 1'b0;
        end
      end
      if (bus.resp_valid && !got_first) begin
        first_y = bus.resp_y;
        got_first = 1'b1;
      end
    end
    bus.req_valid = 1'b0;
    n_cmp++;
    if (n_acc != 2 || (acc1 - acc0) != 34) begin
      n_fail++;
      $display("FAIL b2b_gap: accepts=%0d gap=%0d required 2/34", n_acc, acc1 - acc0);
    end
    n_cmp++;
    if (!got_first || first_y !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL b2b_first: got=%b resp_y=%h required 1/fffffffe", got_first, first_y);
    end
    w = 0;
    while (!bus.resp_valid && w < 64) begin
      @(posedge clk);
      #1;
      w++;
    end
    n_cmp++;
    if (bus.resp_valid !== 1'b1 || bus.resp_y !== 32'h0000_000E) begin
      n_fail++;
      $display("FAIL b2b_second: resp_valid=%b resp_y=%h required 1/0000000e", bus.resp_valid,
               bus.resp_y);
    end
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    bus.resp_ready = 1'b0;
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #2;
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.dbg_state !== CALC) begin
      n_fail++;
      $display("FAIL arst_pre: busy=%b state=%0d required 1/CALC", bus.busy, bus.dbg_state);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL arst_now: req_ready=%b resp_valid=%b busy=%b state=%0d required 1/0/0/IDLE",
               bus.req_ready, bus.resp_valid, bus.busy, bus.dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mul_after_rst", OP_MUL, 32'd3, 32'd4, 32'd12, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
